// File: rtl/long_mul_unit_pkg.sv
// Shared definitions for the long-multiply execution unit: state encoding
// and the default operand width used by the core.
package long_mul_unit_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/long_mul_unit_if.sv
// Request/response bundle between the core controller (master) and the
// long-multiply unit (slave).
//
// Handshake: the master drives the operand fields and raises Start for one
// cycle while Busy is low; the unit latches everything on that edge and
// raises Busy. Start is ignored whenever Busy is high (it is not queued).
// Done pulses for exactly one cycle with ResultHi/ResultLo/Flags valid; the
// result fields then hold until the next operation finishes. dbg_state
// mirrors the internal FSM state for observation only.
interface long_mul_unit_if
  import long_mul_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);

  logic             Start;
  logic             Signed;
  logic             Accumulate;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] AccLo;
  logic [WIDTH-1:0] AccHi;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic [1:0]       Flags;
  state_t           dbg_state;

  modport master (
    output Start, Signed, Accumulate, SrcA, SrcB, AccLo, AccHi,
    input  Busy, Done, ResultLo, ResultHi, Flags, dbg_state
  );

  modport slave (
    input  Start, Signed, Accumulate, SrcA, SrcB, AccLo, AccHi,
    output Busy, Done, ResultLo, ResultHi, Flags, dbg_state
  );

endinterface

// File: rtl/long_mul_unit.sv
// Iterative WIDTHxWIDTH -> 2*WIDTH multiply(-accumulate) unit covering
// UMULL/SMULL/UMLAL/SMLAL. Radix-2 shift-add on operand magnitudes, one
// multiplier bit per cycle, followed by a single sign-correct/accumulate
// step. Latency is fixed regardless of operand values.
module long_mul_unit
  import long_mul_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  long_mul_unit_if.slave     bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    prod;
  logic             negate;
  logic             acc_en;
  logic [PW-1:0]    acc_val;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [1:0]       flags;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   step_sum;
  logic [PW-1:0]    prod_step;
  logic [PW-1:0]    signed_prod;
  logic [PW-1:0]    final_sum;

  // Operand magnitudes; negating the most negative value wraps to itself,
  // which read as unsigned is exactly the required 2^(WIDTH-1).
  always_comb begin
    mag_a = bus.SrcA;
    mag_b = bus.SrcB;
    if (bus.Signed && bus.SrcA[WIDTH-1]) mag_a = -bus.SrcA;
    if (bus.Signed && bus.SrcB[WIDTH-1]) mag_b = -bus.SrcB;
  end

  // One shift-add step: the multiplier sits in the low half of prod and is
  // consumed LSB first while the product grows into the high half.
  always_comb begin
    step_sum  = {1'b0, prod[PW-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    prod_step = {step_sum, prod[WIDTH-1:1]};
  end

  // Sign correction and optional accumulate, all modulo 2^(2*WIDTH).
  always_comb begin
    signed_prod = negate ? -prod : prod;
    final_sum   = signed_prod + (acc_en ? acc_val : {PW{1'b0}});
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; Start only matters in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = CALC;
      CALC:    if (count == CW'(1)) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      mcand     <= '0;
      prod      <= '0;
      negate    <= 1'b0;
      acc_en    <= 1'b0;
      acc_val   <= '0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            count   <= CW'(WIDTH);
            mcand   <= mag_a;
            prod    <= {{WIDTH{1'b0}}, mag_b};
            negate  <= bus.Signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            acc_en  <= bus.Accumulate;
            acc_val <= {bus.AccHi, bus.AccLo};
          end
        end
        CALC: begin
          prod  <= prod_step;
          count <= count - CW'(1);
        end
        FINAL: begin
          result_lo <= final_sum[WIDTH-1:0];
          result_hi <= final_sum[PW-1:WIDTH];
          flags     <= {final_sum[PW-1], (final_sum == {PW{1'b0}})};
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = (state == DONE);
  assign bus.ResultLo  = result_lo;
  assign bus.ResultHi  = result_hi;
  assign bus.Flags     = flags;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_long_mul_unit.sv
// Directed bench for long_mul_unit: hand-computed vectors for the unsigned,
// signed and accumulate variants, Start-while-busy and mid-operation reset.
module tb_long_mul_unit;
  import long_mul_unit_pkg::*;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [1:0]  exp_flags_q[$];

  int done_cyc;
  int busy_cyc;
  int done_cnt;
  int end_cyc;

  long_mul_unit_if #(.WIDTH(32)) bus ();

  long_mul_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Clock and reset generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic acc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    bus.Signed     = s;
    bus.Accumulate = acc;
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.AccHi      = hi;
    bus.AccLo      = lo;
  endtask

  // Issue one Start and follow the operation until Busy drops (bounded).
  // Cycle c is the c-th cycle after the edge that sampled Start.
  task automatic run_op(input logic inject);
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    done_cyc = 0;
    busy_cyc = 0;
    done_cnt = 0;
    end_cyc  = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.Busy) busy_cyc++;
      if (bus.Done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (!bus.Busy) begin
        bus.Start = 1'b0;
        end_cyc = c;
        break;
      end
      if (inject && (c == 5 || c == 34)) begin
        bus.Start = 1'b1;
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0007, 32'h1234_5678, 32'h9ABC_DEF0);
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string tag);
    logic [63:0] exp_res;
    logic [1:0]  exp_fl;
    exp_res = exp_q.pop_front();
    exp_fl  = exp_flags_q.pop_front();
    check({tag, " done_cycle"}, 64'(done_cyc), 64'd34);
    check({tag, " busy_cycles"}, 64'(busy_cyc), 64'd34);
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_low_cycle"}, 64'(end_cyc), 64'd35);
    check({tag, " result"}, {bus.ResultHi, bus.ResultLo}, exp_res);
    check({tag, " flags"}, 64'(bus.Flags), 64'(exp_fl));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.Start = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset busy", 64'(bus.Busy), 64'd0);
    check("reset done", 64'(bus.Done), 64'd0);
    check("reset result", {bus.ResultHi, bus.ResultLo}, 64'd0);
    check("reset flags", 64'(bus.Flags), 64'd0);
    check("reset state", 64'(bus.dbg_state), 64'(IDLE));

    // Unsigned max: N follows ResultHi[31].
    drive(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    exp_q.push_back(64'hFFFF_FFFE_0000_0001); exp_flags_q.push_back(2'b10);
    run_op(1'b0); check_op("umull_max");

    // Signed -1 * 1.
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); exp_flags_q.push_back(2'b10);
    run_op(1'b0); check_op("smull_neg");

    // Signed most-negative squared.
    drive(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0);
    exp_q.push_back(64'h4000_0000_0000_0000); exp_flags_q.push_back(2'b00);
    run_op(1'b0); check_op("smull_minsq");

    // Accumulate wrap: 6 + 0xFFFF_FFFF_FFFF_FFFF.
    drive(1'b0, 1'b1, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back(64'h0000_0000_0000_0005); exp_flags_q.push_back(2'b00);
    run_op(1'b0); check_op("umlal_wrap");

    // Zero operand, full latency, Z set.
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back(64'h0); exp_flags_q.push_back(2'b01);
    run_op(1'b0); check_op("zero");

    // Start while busy (cycle 5 and DONE) with altered operands.
    drive(1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0, 32'h0);
    exp_q.push_back(64'h0000_0001_2345_6780); exp_flags_q.push_back(2'b00);
    run_op(1'b1); check_op("start_busy");
    @(negedge clk);
    check("start_busy ignored", 64'(bus.Busy), 64'd0);

    // Signed accumulate: -2*3 + 10.
    drive(1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0000_000A);
    exp_q.push_back(64'h0000_0000_0000_0004); exp_flags_q.push_back(2'b00);
    run_op(1'b0); check_op("smlal");

    // Signed 5 * -3.
    drive(1'b1, 1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0, 32'h0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1); exp_flags_q.push_back(2'b10);
    run_op(1'b0); check_op("smull_mix");

    // Reset in cycle 10 of CALC aborts with no Done.
    drive(1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 32'h0);
    @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.Busy), 64'd0);
    check("abort done", 64'(bus.Done), 64'd0);
    check("abort result", {bus.ResultHi, bus.ResultLo}, 64'd0);
    check("abort flags", 64'(bus.Flags), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.Done) done_cnt++;
    end
    check("abort no_done", 64'(done_cnt), 64'd0);
    check("abort idle", 64'(bus.Busy), 64'd0);

    // Normal operation after release.
    drive(1'b0, 1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0, 32'h0);
    exp_q.push_back(64'h0000_0000_0000_002A); exp_flags_q.push_back(2'b00);
    run_op(1'b0); check_op("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
